// File: rtl/op_request_queue.sv
// In-order request queue between the trace parser's op interface and the memory
// controller scheduler: show-ahead head with per-entry residency age and overflow accounting.
package op_request_queue_pkg;
  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_NOP    = 2'd3
  } parsed_op_t;
endpackage

module op_request_queue
  import op_request_queue_pkg::*;
#(
  parameter  int DEPTH         = 16,
  parameter  int AGE_W         = 10,
  parameter  int DROP_W        = 16,
  parameter  int ADDRESS_WIDTH = 36,
  localparam int CNT_W         = $clog2(DEPTH + 1),
  localparam int PTR_W         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     op_ready_s,
  input  parsed_op_t               opcode,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     pop,
  input  logic                     clear_overflow,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic [CNT_W-1:0]         count,
  output logic                     head_valid,
  output parsed_op_t               head_opcode,
  output logic [ADDRESS_WIDTH-1:0] head_address,
  output logic [AGE_W-1:0]         head_age,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF   = CNT_W'(DEPTH - 1);

  parsed_op_t               op_mem_q   [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [AGE_W-1:0]         age_q      [DEPTH];
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic [DROP_W-1:0]        drop_q, drop_d;

  logic push_qual_s, pop_eff_s, push_acc_s, drop_s;

  // A full queue still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_qual_s = op_ready_s && (opcode != OP_NOP);
    pop_eff_s   = pop && (count_q != '0);
    push_acc_s  = push_qual_s && ((count_q != CNT_FULL) || pop_eff_s);
    drop_s      = push_qual_s && !push_acc_s;

    wr_ptr_d = push_acc_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_eff_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_acc_s) - CNT_W'(pop_eff_s);

    valid_d = valid_q;
    if (pop_eff_s) begin
      valid_d[rd_ptr_q] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (push_acc_s) begin
      valid_d[wr_ptr_q] = 1'b1;
    end else begin
      valid_d = valid_d;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    if (drop_s && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_mem_q[i]   <= OP_NOP;
        addr_mem_q[i] <= '0;
        age_q[i]      <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      // Freshly written entry starts at age 0; resident entries age and saturate.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_acc_s && (wr_ptr_q == PTR_W'(i))) begin
          op_mem_q[i]   <= opcode;
          addr_mem_q[i] <= address;
          age_q[i]      <= '0;
        end else if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end else begin
          age_q[i] <= age_q[i];
        end
      end
    end
  end

  assign count        = count_q;
  assign full         = (count_q == CNT_FULL);
  assign almost_full  = (count_q >= CNT_AF);
  assign empty        = (count_q == '0);
  assign head_valid   = !empty;
  assign head_opcode  = empty ? OP_NOP : op_mem_q[rd_ptr_q];
  assign head_address = empty ? '0 : addr_mem_q[rd_ptr_q];
  assign head_age     = empty ? '0 : age_q[rd_ptr_q];
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_op_request_queue.sv
// Directed self-checking bench for op_request_queue; a second AGE_W=3 instance
// covers age saturation.
module tb_op_request_queue;
  import op_request_queue_pkg::*;

  localparam int AW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_ready_s, pop, clear_overflow;
  parsed_op_t    opcode;
  logic [AW-1:0] address;
  logic          full, almost_full, empty, head_valid, overflow;
  logic [4:0]    count;
  parsed_op_t    head_opcode;
  logic [AW-1:0] head_address;
  logic [9:0]    head_age;
  logic [15:0]   drop_count;

  logic          sat_ready;
  logic          s_full, s_af, s_empty, s_hv, s_ovf;
  logic [4:0]    s_count;
  parsed_op_t    s_hop;
  logic [AW-1:0] s_haddr;
  logic [2:0]    s_age;
  logic [15:0]   s_drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  op_request_queue #(.DEPTH(16), .AGE_W(10), .DROP_W(16), .ADDRESS_WIDTH(AW)) u_dut (
    .clk(clk), .rst(rst), .op_ready_s(op_ready_s), .opcode(opcode), .address(address),
    .pop(pop), .clear_overflow(clear_overflow), .full(full), .almost_full(almost_full),
    .empty(empty), .count(count), .head_valid(head_valid), .head_opcode(head_opcode),
    .head_address(head_address), .head_age(head_age), .overflow(overflow),
    .drop_count(drop_count)
  );

  op_request_queue #(.DEPTH(16), .AGE_W(3), .DROP_W(16), .ADDRESS_WIDTH(AW)) u_sat (
    .clk(clk), .rst(rst), .op_ready_s(sat_ready), .opcode(OP_READ), .address(36'h0AB),
    .pop(1'b0), .clear_overflow(1'b0), .full(s_full), .almost_full(s_af),
    .empty(s_empty), .count(s_count), .head_valid(s_hv), .head_opcode(s_hop),
    .head_address(s_haddr), .head_age(s_age), .overflow(s_ovf), .drop_count(s_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input parsed_op_t op, input logic [AW-1:0] a);
    op_ready_s = 1'b1; opcode = op; address = a;
    tick();
    op_ready_s = 1'b0; opcode = OP_NOP;
  endtask

  task automatic push_pop(input parsed_op_t op, input logic [AW-1:0] a);
    op_ready_s = 1'b1; opcode = op; address = a; pop = 1'b1;
    tick();
    op_ready_s = 1'b0; opcode = OP_NOP; pop = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_ready_s = 1'b0; opcode = OP_NOP; address = '0;
    pop = 1'b0; clear_overflow = 1'b0; sat_ready = 1'b0;
    tick(); tick();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_af", 64'(almost_full), 64'd0);
    chk("rst_hv", 64'(head_valid), 64'd0);
    chk("rst_hop", 64'(head_opcode), 64'(OP_NOP));
    chk("rst_haddr", 64'(head_address), 64'd0);
    chk("rst_age", 64'(head_age), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;
    tick();

    // Basic push, show-ahead head and age
    push(OP_READ, 36'h1A2B3C4D0);
    chk("p1_hv", 64'(head_valid), 64'd1);
    chk("p1_hop", 64'(head_opcode), 64'(OP_READ));
    chk("p1_haddr", 64'(head_address), 64'h1A2B3C4D0);
    chk("p1_age0", 64'(head_age), 64'd0);
    push(OP_WRITE, 36'h000000040);
    chk("p2_count", 64'(count), 64'd2);
    chk("p2_hop", 64'(head_opcode), 64'(OP_READ));
    chk("p2_age1", 64'(head_age), 64'd1);
    tick(); tick();
    chk("p2_age3", 64'(head_age), 64'd3);
    do_pop();
    chk("p2_pop_hop", 64'(head_opcode), 64'(OP_WRITE));
    chk("p2_pop_haddr", 64'(head_address), 64'h40);
    chk("p2_pop_count", 64'(count), 64'd1);
    do_pop();
    chk("p2_empty", 64'(empty), 64'd1);

    // Fill, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      push((i % 2 == 1) ? OP_IFETCH : OP_READ, AW'(i));
      if (i == 14) begin
        chk("fill_af15", 64'(almost_full), 64'd1);
        chk("fill_nfull15", 64'(full), 64'd0);
      end
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_ovf0", 64'(overflow), 64'd0);
    push(OP_READ, 36'h99);
    chk("drop_full", 64'(full), 64'd1);
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_cnt", 64'(drop_count), 64'd1);
    chk("drop_count16", 64'(count), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_addr", 64'(head_address), 64'(i));
      chk("drain_op", 64'(head_opcode), (i % 2 == 1) ? 64'(OP_IFETCH) : 64'(OP_READ));
      do_pop();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_drop_kept", 64'(drop_count), 64'd1);

    // Full with NOP strobe, push+pop, drop+clear collision
    for (int i = 0; i < 16; i++) push(OP_READ, AW'(16 + i));
    push(OP_NOP, 36'h55);
    chk("nop_drop", 64'(drop_count), 64'd1);
    chk("nop_ovf", 64'(overflow), 64'd0);
    chk("nop_count", 64'(count), 64'd16);
    push_pop(OP_WRITE, 36'h100);
    chk("fpp_count", 64'(count), 64'd16);
    chk("fpp_drop", 64'(drop_count), 64'd1);
    chk("fpp_ovf", 64'(overflow), 64'd0);
    chk("fpp_head", 64'(head_address), 64'h11);
    clear_overflow = 1'b1;
    push(OP_READ, 36'h77);
    clear_overflow = 1'b0;
    chk("dclr_ovf", 64'(overflow), 64'd1);
    chk("dclr_drop", 64'(drop_count), 64'd2);
    for (int i = 1; i < 16; i++) begin
      chk("fpp_order", 64'(head_address), 64'(16 + i));
      do_pop();
    end
    chk("fpp_tail_addr", 64'(head_address), 64'h100);
    chk("fpp_tail_op", 64'(head_opcode), 64'(OP_WRITE));
    do_pop();
    chk("fpp_empty", 64'(empty), 64'd1);

    // Empty queue: pop+push, lone pop
    push_pop(OP_READ, 36'h200);
    chk("epp_count", 64'(count), 64'd1);
    chk("epp_head", 64'(head_address), 64'h200);
    do_pop();
    do_pop();
    chk("epop_count", 64'(count), 64'd0);
    chk("epop_empty", 64'(empty), 64'd1);
    push(OP_IFETCH, 36'h300);
    chk("epop_head", 64'(head_address), 64'h300);
    chk("epop_cnt1", 64'(count), 64'd1);
    do_pop();

    // Interleaved traffic across the pointer wrap
    push(OP_READ, 36'h400);
    for (int i = 1; i < 20; i++) begin
      chk("wrap_order", 64'(head_address), 64'(36'h400 + i - 1));
      push_pop(OP_READ, AW'(36'h400 + i));
    end
    chk("wrap_count", 64'(count), 64'd1);
    chk("wrap_last", 64'(head_address), 64'h413);
    do_pop();
    chk("wrap_empty", 64'(empty), 64'd1);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) push(OP_WRITE, AW'(36'h500 + i));
    chk("mrst_pre", 64'(count), 64'd5);
    #2 rst = 1'b1;
    tick();
    chk("mrst_empty", 64'(empty), 64'd1);
    chk("mrst_drop", 64'(drop_count), 64'd0);
    chk("mrst_hop", 64'(head_opcode), 64'(OP_NOP));
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    tick();

    // Age saturation on the AGE_W=3 instance
    sat_ready = 1'b1;
    tick();
    sat_ready = 1'b0;
    chk("sat_age0", 64'(s_age), 64'd0);
    repeat (5) tick();
    chk("sat_age5", 64'(s_age), 64'd5);
    repeat (5) tick();
    chk("sat_age7", 64'(s_age), 64'd7);
    chk("sat_count", 64'(s_count), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/op_request_queue.md
Name: op_request_queue

Overview:
- Receive end of the trace parser's op interface: captures each parsed op (op_ready_s, opcode, address) into a DEPTH-entry in-order request queue.
- Presents the oldest pending request, with its residency age, to the downstream memory controller scheduler, which removes it with a single-cycle pop.
- Reports occupancy and full status back toward the parser side.
- Counts any ops lost to overflow.

Parameters:
- DEPTH, 16, number of queue entries; power of two, at least 2.
- AGE_W, 10, width of the per-entry age counter in clock cycles.
- DROP_W, 16, width of the dropped-op counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- op_ready_s  in  1  parser strobe: opcode/address valid this cycle.
- opcode  in  parsed_op_t  parsed operation (READ, WRITE, IFETCH, NOP).
- address  in  ADDRESS_WIDTH  parsed address.
- pop  in  1  scheduler removes the head entry this cycle.
- clear_overflow  in  1  clears the overflow sticky flag; drop_count is unaffected.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= DEPTH-1.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- head_valid  out  1  head entry present (equals ~empty).
- head_opcode  out  parsed_op_t  opcode of the oldest entry; NOP when empty.
- head_address  out  ADDRESS_WIDTH  address of the oldest entry; 0 when empty.
- head_age  out  AGE_W  cycles the head has resided in the queue; 0 when empty.
- overflow  out  1  sticky: set when an op was dropped.
- drop_count  out  DROP_W  saturating count of dropped ops.

Behaviour:
- Reset (asynchronous, active-high, also mid-operation): wr_ptr, rd_ptr and count go to 0; all entries invalidated; overflow 0; drop_count 0. Outputs then read empty=1, full=0, almost_full=0, head_valid=0, head_opcode=NOP, head_address=0, head_age=0. Storage payload is don't-care.
- Push qualifier: op_ready_s==1 and opcode!=NOP. A strobe carrying NOP is ignored and is not counted as a drop.
- Push accepted when a qualified push occurs and (count<DEPTH or an effective pop occurs in the same cycle).
  - Entry written at wr_ptr with age 0.
  - wr_ptr increments modulo DEPTH.
- Effective pop: pop==1 and count>0. The head entry is discarded and rd_ptr increments modulo DEPTH. A pop while empty is ignored with no error.
- Drop: qualified push while count==DEPTH with no effective pop in the same cycle.
  - Entry is not written.
  - overflow set at next edge.
  - drop_count increments, saturating at 2^DROP_W-1.
- Count update at next edge: count + push_accepted - effective_pop. Push and pop in the same cycle leave count unchanged.
- Push into an empty queue with pop asserted: pop is ignored and the push is accepted (count becomes 1).
- Show-ahead head: head_opcode, head_address and head_age are combinational reads of storage at rd_ptr. No read latency; the value popped is the one visible in the pop cycle.
- Push-to-head latency: a push into an empty queue is visible at head one cycle after the accept edge.
- Ages: every valid entry's age increments by 1 each cycle, saturating at 2^AGE_W-1. The entry written this cycle starts at 0. Ages of popped entries are irrelevant.
- clear_overflow: clears overflow at next edge. A drop in the same cycle wins, so overflow stays 1.
- Pointer wrap: wr_ptr and rd_ptr wrap at DEPTH. full/empty are derived from count, not from pointer equality.
- Ordering: strict FIFO; no reordering, no merging of duplicate addresses.

Test Plan:
- Reset, then push READ @0x1A2B3C4D0 at cycle 5 and WRITE @0x000000040 at cycle 6 → count=2. Head is READ/0x1A2B3C4D0 from cycle 6. At cycle 9 (no pop): head_age=3.
- Fill 16 entries with addresses 0x0..0xF, then push one more with no pop → full=1, overflow=1, drop_count=1. Popping 16 times returns 0x0..0xF in order, then empty=1.
- Queue full, same-cycle push(0x100)+pop → count stays 16, no drop, overflow=0. The tail entry after 15 further pops is 0x100.
- Empty queue, same-cycle pop+push(0x200) → count=1, head=0x200. A pop on an empty queue with no push leaves count=0 and pointers unchanged.
- Push 20 and pop 20 interleaved (pointer wrap) → order preserved. Assert rst with 5 entries queued → next cycle empty=1, drop_count=0, head_opcode=NOP.
- op_ready_s=1 with opcode=NOP while full → no drop, overflow stays 0. Saturation check with AGE_W=3: head held 10 cycles → head_age=7.
